// File: rtl/regbank_pkg.sv
// regbank_pkg: shared state encoding and default widths for the register-bank write arbiter
package regbank_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/regbank_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set req at or after ptr
// Ports: req (requests), ptr (search start) -> grant (one-hot), idx (encoded winner), any (some req set)
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        idx = PW'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: round-robin sharing of a register bank's write port plus a sequenced bank clear
// Ports: clock/reset (async high), clock_valid (edge enable), req/req_addr/req_data (packed per requester),
//        grant (combinational one-hot), clear_req/clear_done, reg_write/reg_data/reg_clear (registered bank pins)
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = regbank_pkg::ADDR_W,
  parameter int DATA_W   = regbank_pkg::DATA_W,
  parameter int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clock_valid,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  input  logic                        clear_req,
  output logic                        clear_done,
  output logic [NUM_REGS-1:0]         reg_write,
  output logic [DATA_W-1:0]           reg_data,
  output logic                        reg_clear
);
  state_t state, state_nxt;
  logic [PW-1:0]       rr_ptr, pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                pick_any, grant_en, accept;
  logic [ADDR_W-1:0]   win_addr;
  logic [NUM_REGS-1:0] wr_hot;
  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );
  // Grant depends only on state, inputs and rr_ptr, never on the reg_* outputs.
  assign grant_en = clock_valid && state == ST_RUN && !clear_req;
  assign grant    = grant_en ? pick_grant : '0;
  assign accept   = grant_en && pick_any;
  assign win_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
  // Out-of-range indices match no bit, so the write is silently dropped.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) wr_hot[r] = int'(win_addr) == r;
  end
  always_comb begin
    state_nxt = state == ST_RUN   ? (clear_req ? ST_DRAIN : ST_RUN) :
                state == ST_DRAIN ? ST_CLEAR :
                state == ST_CLEAR ? ST_DONE  : ST_RUN;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      rr_ptr     <= '0;
      reg_write  <= '0;
      reg_data   <= '0;
      reg_clear  <= 1'b0;
      clear_done <= 1'b0;
    end else if (clock_valid) begin
      state      <= state_nxt;
      reg_write  <= accept ? wr_hot : '0;
      reg_clear  <= state == ST_CLEAR;
      clear_done <= state == ST_DONE;
      if (accept) begin
        reg_data <= req_data[pick_idx*DATA_W +: DATA_W];
        rr_ptr   <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: directed stimulus with a scoreboard of expected bank-pin events
module tb_regbank_write_arbiter;
  typedef struct packed {
    logic [7:0]  wr;
    logic [15:0] data;
    logic        clr;
    logic        done;
  } ev_t;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clock_valid = 1'b1;
  logic [3:0]  req = '0;
  logic        clear_req = 1'b0;
  logic [2:0]  a [4];
  logic [15:0] d [4];
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  grant, grant6;
  logic        clear_done, clear_done6, reg_clear, reg_clear6;
  logic [7:0]  reg_write;
  logic [5:0]  reg_write6;
  logic [15:0] reg_data, reg_data6;
  ev_t         q [$];
  int          tests = 0;
  int          fails = 0;
  int          gcnt [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_addr[i*3 +: 3]   = a[i];
      req_data[i*16 +: 16] = d[i];
    end
  end
  regbank_write_arbiter dut (
    .clock(clock), .reset(reset), .clock_valid(clock_valid),
    .req(req), .req_addr(req_addr), .req_data(req_data), .grant(grant),
    .clear_req(clear_req), .clear_done(clear_done),
    .reg_write(reg_write), .reg_data(reg_data), .reg_clear(reg_clear)
  );
  regbank_write_arbiter #(.NUM_REGS(6)) dut6 (
    .clock(clock), .reset(reset), .clock_valid(clock_valid),
    .req(req), .req_addr(req_addr), .req_data(req_data), .grant(grant6),
    .clear_req(clear_req), .clear_done(clear_done6),
    .reg_write(reg_write6), .reg_data(reg_data6), .reg_clear(reg_clear6)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // One cycle: drive req, check grant before the edge, queue the write it should produce.
  task automatic cyc(input logic [3:0] r, input logic [3:0] exp_g, input string nm);
    req = r;
    #3;
    chk(nm, 32'(grant), 32'(exp_g));
    for (int i = 0; i < 4; i++) begin
      if (exp_g[i]) begin
        gcnt[i]++;
        q.push_back('{wr: 8'(1) << a[i], data: d[i], clr: 1'b0, done: 1'b0});
      end
    end
    @(posedge clock);
    #1;
  endtask
  // Monitor: once per valid cycle, any activity on the bank pins must match the queue head.
  always @(negedge clock) begin
    if (!reset && clock_valid && (reg_write != '0 || reg_clear || clear_done)) begin
      if (q.size() == 0) begin
        chk("unexpected_bank_event", {reg_write, reg_clear, clear_done}, 32'h0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("bank_write", 32'(reg_write), 32'(e.wr));
        if (e.wr != '0) chk("bank_data", 32'(reg_data), 32'(e.data));
        chk("bank_clear", 32'(reg_clear), 32'(e.clr));
        chk("bank_done", 32'(clear_done), 32'(e.done));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      a[i] = 3'(i);
      d[i] = 16'h1111 * 16'(i + 1);
      gcnt[i] = 0;
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #3;
    chk("rst_reg_write", 32'(reg_write), 32'h0);
    chk("rst_reg_data", 32'(reg_data), 32'h0);
    chk("rst_reg_clear", 32'(reg_clear), 32'h0);
    chk("rst_clear_done", 32'(clear_done), 32'h0);
    chk("rst_grant_idle", 32'(grant), 32'h0);
    @(posedge clock);
    #1;
    a[0] = 3'd5;
    d[0] = 16'hBEEF;
    cyc(4'b0001, 4'b0001, "single_grant");
    cyc(4'b0000, 4'b0000, "single_idle");
    cyc(4'b0000, 4'b0000, "single_idle2");
    a[0] = 3'd0;
    d[0] = 16'h1111;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    cyc(4'b1111, 4'b0010, "rr_1");
    cyc(4'b1111, 4'b0100, "rr_2");
    cyc(4'b1111, 4'b1000, "rr_3");
    cyc(4'b1111, 4'b0001, "rr_4");
    cyc(4'b1111, 4'b0010, "rr_5");
    cyc(4'b1111, 4'b0100, "rr_6");
    cyc(4'b1111, 4'b1000, "rr_7");
    cyc(4'b1111, 4'b0001, "rr_8");
    for (int i = 0; i < 4; i++) chk($sformatf("rr_count_%0d", i), 32'(gcnt[i]), 32'd2);
    cyc(4'b1111, 4'b0010, "stall_pre");
    clock_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cyc(4'b1111, 4'b0000, "stall_grant");
      chk("stall_reg_write", 32'(reg_write), 32'h02);
      chk("stall_reg_data", 32'(reg_data), 32'h2222);
    end
    clock_valid = 1'b1;
    cyc(4'b1111, 4'b0100, "stall_resume_1");
    cyc(4'b1111, 4'b1000, "stall_resume_2");
    cyc(4'b0000, 4'b0000, "pre_clear_idle");
    a[0] = 3'd2;
    d[0] = 16'hABCD;
    cyc(4'b0001, 4'b0001, "clr_write");
    clear_req = 1'b1;
    cyc(4'b1111, 4'b0000, "clr_run_block");
    clear_req = 1'b0;
    cyc(4'b1111, 4'b0000, "clr_drain");
    chk("clr_drain_write", 32'(reg_write), 32'h0);
    cyc(4'b1111, 4'b0000, "clr_clear");
    q.push_back('{wr: 8'h0, data: 16'h0, clr: 1'b1, done: 1'b0});
    cyc(4'b1111, 4'b0000, "clr_done_state");
    q.push_back('{wr: 8'h0, data: 16'h0, clr: 1'b0, done: 1'b1});
    cyc(4'b1111, 4'b0010, "clr_after_grant");
    cyc(4'b0000, 4'b0000, "clr_idle");
    a[2] = 3'd7;
    d[2] = 16'h7777;
    cyc(4'b0100, 4'b0100, "oor_grant");
    chk("oor_grant6", 32'(grant6), 32'h4);
    req = 4'b1111;
    #3;
    chk("oor_reg_write6", 32'(reg_write6), 32'h0);
    chk("oor_ptr_adv6", 32'(grant6), 32'h8);
    #(-3 + 3);
    cyc(4'b1111, 4'b1000, "oor_next");
    cyc(4'b0000, 4'b0000, "oor_idle");
    cyc(4'b0010, 4'b0010, "ar_write");
    clear_req = 1'b1;
    cyc(4'b0000, 4'b0000, "ar_run");
    clear_req = 1'b0;
    cyc(4'b0000, 4'b0000, "ar_drain");
    #1;
    reset = 1'b1;
    req = 4'b1111;
    #1;
    chk("ar_reg_clear", 32'(reg_clear), 32'h0);
    chk("ar_clear_done", 32'(clear_done), 32'h0);
    chk("ar_grant_rst", 32'(grant), 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(4'b1111, 4'b0001, "ar_first_grant");
    cyc(4'b0000, 4'b0000, "end_idle_1");
    cyc(4'b0000, 4'b0000, "end_idle_2");
    cyc(4'b0000, 4'b0000, "end_idle_3");
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
